// File: rtl/pkt_event_tap_pkg.sv
// Shared types and defaults for the packet event tap.
package pkt_tap_pkg;

   // Default widths for the egress port and the byte-count accumulator
   localparam int unsigned PORT_W_DEF = 9;
   localparam int unsigned LEN_W_DEF  = 16;

   // Raw state codes kept for code that still compares against bit patterns
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_IN_PKT = 1'b1;

   typedef enum logic [0:0] {
      IDLE   = ST_IDLE,
      IN_PKT = ST_IN_PKT
   } tap_state_e;

   // Event record at the default widths; the tap keeps the same field order
   typedef struct packed {
      logic                  drop;
      logic [LEN_W_DEF-1:0]  length;
      logic [PORT_W_DEF-1:0] egress_port;
      logic                  oversize;
      logic                  meta_missing;
   } pkt_event_t;

endpackage

// File: rtl/pkt_event_tap_if.sv
// Observed AXI-Stream handshake plus first-beat forwarding metadata.
interface pkt_event_tap_if
   import pkt_tap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned PORT_W     = PORT_W_DEF
);
   localparam int unsigned KEEP_W = DATA_WIDTH / 8;

   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [KEEP_W-1:0] s_axis_tkeep;
   logic              s_axis_tlast;
   logic              meta_valid;
   logic [PORT_W-1:0] meta_egress_port;
   logic              meta_drop;

   // Stream/metadata source side
   modport master (
      output s_axis_tvalid, s_axis_tready, s_axis_tkeep, s_axis_tlast,
      output meta_valid, meta_egress_port, meta_drop
   );

   // Passive observer side: everything is an input, no ready is driven
   modport slave (
      input s_axis_tvalid, s_axis_tready, s_axis_tkeep, s_axis_tlast,
      input meta_valid, meta_egress_port, meta_drop
   );
endinterface

// File: rtl/pkt_event_tap_keep_popcount.sv
// Counts set byte enables in a tkeep word (gaps allowed).
module keep_popcount #(
   parameter int unsigned KEEP_W = 64
) (
   input  logic [KEEP_W-1:0]       keep_i,
   output logic [$clog2(KEEP_W):0] count_o
);
   localparam int unsigned CNT_W = $clog2(KEEP_W) + 1;

   // Plain bit-serial sum; synthesis builds the adder tree
   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < KEEP_W; i++) begin
         count_o = count_o + CNT_W'(keep_i[i]);
      end
   end
endmodule

// File: rtl/pkt_event_tap.sv
// Passive packet tap: accumulates bytes per packet, emits one registered
// event per packet with length, egress port and drop/oversize/missing flags.
module pkt_event_tap
   import pkt_tap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned PORT_W     = PORT_W_DEF,
   parameter int unsigned LEN_W      = LEN_W_DEF
) (
   input  logic              aclk,
   input  logic              aresetn,
   pkt_event_tap_if.slave    tap,
   output logic              packet_valid,
   output logic              packet_last,
   output logic              packet_drop,
   output logic [LEN_W-1:0]  packet_length,
   output logic [PORT_W-1:0] egress_port,
   output logic              pkt_oversize,
   output logic              meta_missing,
   output logic              in_packet
);
   localparam int unsigned KEEP_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(KEEP_W) + 1;

   typedef struct packed {
      logic              drop;
      logic [LEN_W-1:0]  length;
      logic [PORT_W-1:0] egress_port;
      logic              oversize;
      logic              meta_missing;
   } tap_event_t;

   // Packet-in-progress context
   tap_state_e        state_q, state_d;
   logic [LEN_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              drop_q, drop_d;
   logic [PORT_W-1:0] port_q, port_d;
   logic              miss_q, miss_d;

   // Registered event
   logic              ev_valid_q, ev_valid_d;
   tap_event_t        ev_q, ev_d;

   // Per-beat working values
   logic              beat;
   logic              first;
   logic [CNT_W-1:0]  beat_bytes;
   logic [LEN_W:0]    bytes_ext;
   logic [LEN_W-1:0]  base_acc;
   logic              base_ovf;
   logic [LEN_W:0]    sum;
   logic              sat;
   logic [LEN_W-1:0]  new_acc;
   logic              new_ovf;
   logic              cur_drop;
   logic [PORT_W-1:0] cur_port;
   logic              cur_miss;

   keep_popcount #(
      .KEEP_W (KEEP_W)
   ) u_popcount (
      .keep_i  (tap.s_axis_tkeep),
      .count_o (beat_bytes)
   );

   assign beat      = tap.s_axis_tvalid & tap.s_axis_tready;
   assign first     = (state_q == IDLE);
   assign bytes_ext = (LEN_W + 1)'(beat_bytes);

   // First beat starts from zero and samples metadata; later beats reuse the held context
   always_comb begin
      base_acc = first ? '0 : acc_q;
      base_ovf = first ? 1'b0 : ovf_q;
      sum      = {1'b0, base_acc} + bytes_ext;
      sat      = sum[LEN_W];
      new_acc  = sat ? '1 : sum[LEN_W-1:0];
      new_ovf  = base_ovf | sat;
      if (first) begin
         cur_drop = tap.meta_valid ? tap.meta_drop : 1'b1;
         cur_port = tap.meta_valid ? tap.meta_egress_port : '0;
         cur_miss = ~tap.meta_valid;
      end else begin
         cur_drop = drop_q;
         cur_port = port_q;
         cur_miss = miss_q;
      end
   end

   // Next-state: accepted beats update the context; tlast closes the packet and emits the event
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      drop_d     = drop_q;
      port_d     = port_q;
      miss_d     = miss_q;
      ev_valid_d = 1'b0;
      ev_d       = ev_q;
      if (beat) begin
         acc_d  = new_acc;
         ovf_d  = new_ovf;
         drop_d = cur_drop;
         port_d = cur_port;
         miss_d = cur_miss;
         if (tap.s_axis_tlast) begin
            state_d          = IDLE;
            ev_valid_d       = 1'b1;
            ev_d.drop         = cur_drop;
            ev_d.length       = new_acc;
            ev_d.egress_port  = cur_port;
            ev_d.oversize     = new_ovf;
            ev_d.meta_missing = cur_miss;
         end else begin
            state_d = IN_PKT;
         end
      end
   end

   // State and event registers with synchronous active-low reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         drop_q     <= 1'b0;
         port_q     <= '0;
         miss_q     <= 1'b0;
         ev_valid_q <= 1'b0;
         ev_q       <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
         port_q     <= port_d;
         miss_q     <= miss_d;
         ev_valid_q <= ev_valid_d;
         ev_q       <= ev_d;
      end
   end

   assign packet_valid  = ev_valid_q;
   assign packet_last   = ev_valid_q;
   assign packet_drop   = ev_q.drop;
   assign packet_length = ev_q.length;
   assign egress_port   = ev_q.egress_port;
   assign pkt_oversize  = ev_q.oversize;
   assign meta_missing  = ev_q.meta_missing;
   assign in_packet     = (state_q == IN_PKT);

endmodule

// File: tb/tb_pkt_event_tap.sv
// Directed bench for pkt_event_tap: table of single-cycle vectors plus
// hand-written saturation and mid-packet reset sequences.
module tb_pkt_event_tap;

   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   logic aclk;
   logic aresetn;

   pkt_event_tap_if #(.DATA_WIDTH(512), .PORT_W(9)) bus ();

   logic        pv16, pl16, drop16, ovf16, miss16, ip16;
   logic [15:0] len16;
   logic [8:0]  port16;
   logic        pv8, pl8, drop8, ovf8, miss8, ip8;
   logic [7:0]  len8;
   logic [8:0]  port8;

   pkt_event_tap #(.DATA_WIDTH(512), .PORT_W(9), .LEN_W(16)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .tap           (bus),
      .packet_valid  (pv16),
      .packet_last   (pl16),
      .packet_drop   (drop16),
      .packet_length (len16),
      .egress_port   (port16),
      .pkt_oversize  (ovf16),
      .meta_missing  (miss16),
      .in_packet     (ip16)
   );

   pkt_event_tap #(.DATA_WIDTH(512), .PORT_W(9), .LEN_W(8)) dut8 (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .tap           (bus),
      .packet_valid  (pv8),
      .packet_last   (pl8),
      .packet_drop   (drop8),
      .packet_length (len8),
      .egress_port   (port8),
      .pkt_oversize  (ovf8),
      .meta_missing  (miss8),
      .in_packet     (ip8)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        tv, tr;
      logic [63:0] keep;
      logic        tl, mv;
      logic [8:0]  mp;
      logic        md;
      logic        pv, ip, drop;
      logic [15:0] len;
      logic [8:0]  port;
      logic        ovf, miss;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input int tv, input int tr, input logic [63:0] keep,
                               input int tl, input int mv, input int mp, input int md,
                               input int pv, input int ip, input int drop, input int len,
                               input int port, input int ovf, input int miss);
      vec_t v;
      v.tv = (tv != 0); v.tr = (tr != 0); v.keep = keep; v.tl = (tl != 0);
      v.mv = (mv != 0); v.mp = 9'(mp); v.md = (md != 0);
      v.pv = (pv != 0); v.ip = (ip != 0); v.drop = (drop != 0);
      v.len = 16'(len); v.port = 9'(port); v.ovf = (ovf != 0); v.miss = (miss != 0);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic tv, input logic tr, input logic [63:0] keep,
                        input logic tl, input logic mv, input logic [8:0] mp, input logic md);
      bus.s_axis_tvalid    = tv;
      bus.s_axis_tready    = tr;
      bus.s_axis_tkeep     = keep;
      bus.s_axis_tlast     = tl;
      bus.meta_valid       = mv;
      bus.meta_egress_port = mp;
      bus.meta_drop        = md;
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pv16"},   32'(pv16),   0);
      chk({tag, "_pl16"},   32'(pl16),   0);
      chk({tag, "_drop16"}, 32'(drop16), 0);
      chk({tag, "_len16"},  32'(len16),  0);
      chk({tag, "_port16"}, 32'(port16), 0);
      chk({tag, "_ovf16"},  32'(ovf16),  0);
      chk({tag, "_miss16"}, 32'(miss16), 0);
      chk({tag, "_ip16"},   32'(ip16),   0);
      chk({tag, "_pv8"},    32'(pv8),    0);
      chk({tag, "_len8"},   32'(len8),   0);
   endtask

   initial begin
      // tv tr keep tl mv mp md | pv ip drop len port ovf miss
      vecs[0]  = mk(1, 1, ALL,      0, 1, 5, 0,  0, 1, 0,   0, 0, 0, 0);
      vecs[1]  = mk(1, 1, ALL,      0, 0, 7, 1,  0, 1, 0,   0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 64'h0F,   1, 1, 9, 1,  1, 0, 0, 132, 5, 0, 0);
      vecs[3]  = mk(0, 0, 64'h0,    0, 0, 0, 0,  0, 0, 0, 132, 5, 0, 0);
      vecs[4]  = mk(1, 1, 64'h3F,   1, 1, 2, 1,  1, 0, 1,   6, 2, 0, 0);
      vecs[5]  = mk(0, 0, 64'h0,    0, 0, 0, 0,  0, 0, 1,   6, 2, 0, 0);
      vecs[6]  = mk(1, 1, ALL,      0, 0, 3, 0,  0, 1, 1,   6, 2, 0, 0);
      vecs[7]  = mk(1, 1, 64'hFF,   1, 1, 4, 0,  1, 0, 1,  72, 0, 0, 1);
      vecs[8]  = mk(1, 1, ALL,      0, 1, 1, 0,  0, 1, 1,  72, 0, 0, 1);
      vecs[9]  = mk(1, 0, ALL,      1, 1, 9, 1,  0, 1, 1,  72, 0, 0, 1);
      vecs[10] = mk(1, 0, ALL,      1, 1, 9, 1,  0, 1, 1,  72, 0, 0, 1);
      vecs[11] = mk(1, 0, ALL,      1, 1, 9, 1,  0, 1, 1,  72, 0, 0, 1);
      vecs[12] = mk(1, 0, ALL,      1, 1, 9, 1,  0, 1, 1,  72, 0, 0, 1);
      vecs[13] = mk(1, 1, 64'h03,   1, 0, 0, 0,  1, 0, 0,  66, 1, 0, 0);
      vecs[14] = mk(1, 1, 64'h01,   1, 1, 6, 0,  1, 0, 0,   1, 6, 0, 0);
      vecs[15] = mk(1, 1, ALL,      0, 1, 8, 1,  0, 1, 0,   1, 6, 0, 0);
      vecs[16] = mk(1, 1, 64'h00,   1, 0, 0, 0,  1, 0, 1,  64, 8, 0, 0);
      vecs[17] = mk(0, 1, ALL,      1, 1, 3, 0,  0, 0, 1,  64, 8, 0, 0);

      // Reset with activity on the bus: everything must read zero
      aresetn = 1'b0;
      drive(1'b1, 1'b1, ALL, 1'b1, 1'b1, 9'd7, 1'b1);
      tick();
      tick();
      chk_zero("reset");
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      aresetn = 1'b1;
      tick();

      // Table: packets, metadata-missing, stalls, back-to-back, zero-keep
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].tv, vecs[i].tr, vecs[i].keep, vecs[i].tl,
               vecs[i].mv, vecs[i].mp, vecs[i].md);
         tick();
         chk($sformatf("v%0d_pv", i),   32'(pv16),   32'(vecs[i].pv));
         chk($sformatf("v%0d_pl", i),   32'(pl16),   32'(vecs[i].pv));
         chk($sformatf("v%0d_ip", i),   32'(ip16),   32'(vecs[i].ip));
         chk($sformatf("v%0d_drop", i), 32'(drop16), 32'(vecs[i].drop));
         chk($sformatf("v%0d_len", i),  32'(len16),  32'(vecs[i].len));
         chk($sformatf("v%0d_port", i), 32'(port16), 32'(vecs[i].port));
         chk($sformatf("v%0d_ovf", i),  32'(ovf16),  32'(vecs[i].ovf));
         chk($sformatf("v%0d_miss", i), 32'(miss16), 32'(vecs[i].miss));
      end

      // Saturation: 5 full beats = 320 bytes, 8-bit length saturates at 255
      for (int b = 0; b < 5; b++) begin
         drive(1'b1, 1'b1, ALL, (b == 4), 1'b1, 9'd3, 1'b0);
         tick();
         if (b < 4) begin
            chk($sformatf("sat_b%0d_pv8", b), 32'(pv8), 0);
            chk($sformatf("sat_b%0d_ip8", b), 32'(ip8), 1);
         end
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("sat_pv8",    32'(pv8),   1);
      chk("sat_len8",   32'(len8),  255);
      chk("sat_ovf8",   32'(ovf8),  1);
      chk("sat_port8",  32'(port8), 3);
      chk("sat_drop8",  32'(drop8), 0);
      chk("sat_miss8",  32'(miss8), 0);
      chk("sat_len16",  32'(len16), 320);
      chk("sat_ovf16",  32'(ovf16), 0);
      tick();
      chk("sat_hold_pv8",  32'(pv8),  0);
      chk("sat_hold_ovf8", 32'(ovf8), 1);
      chk("sat_hold_len8", 32'(len8), 255);
      // Oversize must not leak into the next packet
      drive(1'b1, 1'b1, 64'h0F, 1'b1, 1'b1, 9'd4, 1'b0);
      tick();
      chk("post_sat_pv8",  32'(pv8),  1);
      chk("post_sat_len8", 32'(len8), 4);
      chk("post_sat_ovf8", 32'(ovf8), 0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      tick();

      // Mid-packet reset: beats 1-2, reset, then beats 3-4 form a new packet
      drive(1'b1, 1'b1, ALL, 1'b0, 1'b1, 9'd2, 1'b0);
      tick();
      drive(1'b1, 1'b1, ALL, 1'b0, 1'b0, 9'd0, 1'b0);
      tick();
      chk("rst_mid_ip", 32'(ip16), 1);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      aresetn = 1'b0;
      tick();
      chk_zero("rst_mid");
      aresetn = 1'b1;
      drive(1'b1, 1'b1, ALL, 1'b0, 1'b1, 9'd5, 1'b0);
      tick();
      chk("rst_b3_pv", 32'(pv16), 0);
      chk("rst_b3_ip", 32'(ip16), 1);
      drive(1'b1, 1'b1, 64'h0F, 1'b1, 1'b1, 9'd1, 1'b1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("rst_ev_pv",   32'(pv16),   1);
      chk("rst_ev_len",  32'(len16),  68);
      chk("rst_ev_port", 32'(port16), 5);
      chk("rst_ev_drop", 32'(drop16), 0);
      chk("rst_ev_miss", 32'(miss16), 0);
      chk("rst_ev_len8", 32'(len8),   68);
      tick();
      chk("rst_end_pv", 32'(pv16), 0);
      chk("rst_end_ip", 32'(ip16), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
